dds_fword_ctrl: RTL and testbench
=================================

// Module: dds_fword_ctrl
// PURPOSE
//  Command sequencer between the SPI slave byte stream and the DDS phase accumulator.
//  Parses 5-byte frames (command + 32-bit word, MSB first) and stages the tuning word in a shadow register.
//  Commits the word to the accumulator FWORD input glitch-free, aligned to the DDS sample strobe.
//  Also owns the output-enable flag and builds the status byte returned on the next SPI transfer.
// PARAMETERS
//  DEFAULT_FWORD  32'd0    FWORD value loaded on reset
//  TIMEOUT        30000    max clk cycles between bytes of one frame before abort (>=2)
//  APPLY_SYNC     1        1: commit on next dds_strobe; 0: commit cycle after last byte
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  rx_byte      in   8   received SPI byte, valid when rx_valid=1
//  rx_valid     in   1   one-cycle pulse per received byte, already in clk domain
//  cs           in   1   SPI chip select (active-low), already synchronised; high aborts an open frame
//  dds_strobe   in   1   one-cycle pulse, phase accumulator sample instant
//  fword_out    out  32  tuning word to accumulator FWORD
//  fword_upd    out  1   one-cycle pulse in the cycle fword_out changes
//  out_en       out  1   DDS output enable
//  busy         out  1   high in COLLECT or PEND
//  tx_byte      out  8   status {pend, out_en, err_to, err_cmd, frame_cnt[3:0]}
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): fword_out=DEFAULT_FWORD, fword_upd=0, out_en=0, busy=0,
//   shadow=0, byte_idx=0, tmo_cnt=0, err flags=0, frame_cnt=0, state=IDLE. Overrides all other inputs.
//  Commands: 8'hA1 LOAD (4 data bytes follow), 8'hA2 ENABLE, 8'hA3 DISABLE; anything else -> err_cmd=1, stay IDLE.
//  FSM:
//   IDLE: rx_valid & A1 -> COLLECT (byte_idx=0, tmo_cnt=0). rx_valid & A2/A3 -> out_en=1/0 same edge,
//     frame_cnt++, stay IDLE.
//   COLLECT: each rx_valid shifts byte into shadow (shadow={shadow[23:0],rx_byte}), byte_idx++, tmo_cnt=0.
//     4th byte (byte_idx==3) -> PEND. No rx_valid -> tmo_cnt++; tmo_cnt==TIMEOUT-1 -> err_to=1, IDLE.
//     cs=1 -> IDLE without error (host ended frame); shadow contents discarded.
//   PEND: APPLY_SYNC=1: wait dds_strobe; on it fword_out<=shadow, fword_upd=1 next cycle, frame_cnt++, IDLE.
//     APPLY_SYNC=0: commit on first PEND cycle unconditionally.
//     rx_valid in PEND: byte dropped, err_cmd=1; commit still occurs.
//  Latency: 4th data byte rx_valid at edge N -> PEND at N; earliest commit (strobe at N+1) updates fword_out at N+1.
//  dds_strobe coincident with 4th byte: not used (state not yet PEND); next strobe commits.
//  fword_out never changes except via commit or reset; changes only when dds_strobe high (APPLY_SYNC=1).
//  frame_cnt 4-bit, wraps 15->0. err_to/err_cmd sticky; cleared only when status byte read:
//   clear on cs rising edge (0->1) detected in IDLE, i.e. after host has clocked tx_byte out.
//  tx_byte registered, updated every cycle from current flags; pend=(state==PEND).
//  TIMEOUT counter saturates logic: compare width = $clog2(TIMEOUT); no wrap past TIMEOUT-1.
//  out_en unaffected by LOAD, timeouts or errors.
// TESTING
//  1 Reset: rst=1 2 cycles -> fword_out=DEFAULT_FWORD, out_en=0, tx_byte=8'h00, busy=0.
//  2 Load: A1,C5,B0,5B,28 bytes, strobe 10 cycles later -> fword_out=32'hC5B05B28 exactly at that strobe,
//    fword_upd single pulse, frame_cnt=1, no change before strobe.
//  3 Timeout: A1,12,34 then silence TIMEOUT cycles -> IDLE, err_to=1, fword_out unchanged, tx_byte[5]=1.
//  4 Abort: A1,12 then cs=1 -> IDLE, no error, fword_out unchanged; next full frame loads correctly.
//  5 Control: A2 -> out_en=1 next cycle; 7F -> err_cmd=1; A3 -> out_en=0; cs rise in IDLE clears errors.
//  6 Reset mid-frame: A1,AA,BB then rst=1 -> all reset values; following A1 frame loads cleanly.

Source files
------------

// File: rtl/dds_fword_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_fword_ctrl_if
//  Description : Bundles the SPI byte stream, DDS strobe and the controller
//                outputs between the host side and dds_fword_ctrl.
//                master : drives rx_byte, rx_valid, cs, dds_strobe
//                         and observes fword_out, fword_upd, out_en, busy,
//                         tx_byte
//                slave  : the controller (mirror directions)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dds_fword_ctrl_if;
    logic [7:0]  rx_byte;     // received SPI byte, qualified by rx_valid
    logic        rx_valid;    // one-cycle pulse per received byte
    logic        cs;          // SPI chip select, active-low, synchronised
    logic        dds_strobe;  // phase accumulator sample instant
    logic [31:0] fword_out;   // tuning word to the accumulator
    logic        fword_upd;   // pulse in the cycle fword_out changes
    logic        out_en;      // DDS output enable
    logic        busy;        // frame being collected or commit pending
    logic [7:0]  tx_byte;     // status byte for the next SPI transfer

    modport master (
        output rx_byte, rx_valid, cs, dds_strobe,
        input  fword_out, fword_upd, out_en, busy, tx_byte
    );

    modport slave (
        input  rx_byte, rx_valid, cs, dds_strobe,
        output fword_out, fword_upd, out_en, busy, tx_byte
    );
endinterface
`default_nettype wire

// File: rtl/dds_fword_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_fword_ctrl
//  Description : Command sequencer between the SPI slave byte stream and the
//                DDS phase accumulator. Parses LOAD/ENABLE/DISABLE frames,
//                stages the 32-bit tuning word in a shadow register and
//                commits it to fword_out aligned to dds_strobe. Builds the
//                status byte {pend, out_en, err_to, err_cmd, frame_cnt[3:0]}.
//  Ports       : clk, rst (sync, active-high)
//                bus.slave : rx_byte/rx_valid/cs/dds_strobe in,
//                            fword_out/fword_upd/out_en/busy/tx_byte out
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_fword_ctrl #(
    parameter logic [31:0] DEFAULT_FWORD = 32'd0,
    parameter int unsigned TIMEOUT       = 30000,
    parameter bit          APPLY_SYNC    = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dds_fword_ctrl_if.slave  bus
);

    localparam int unsigned          c_TMO_W    = $clog2(TIMEOUT);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]           c_CMD_LOAD = 8'hA1;
    localparam logic [7:0]           c_CMD_EN   = 8'hA2;
    localparam logic [7:0]           c_CMD_DIS  = 8'hA3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PEND    = 2'd2
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [31:0]          r_shadow,    w_shadow_nxt;
    logic [1:0]           r_byte_idx,  w_byte_idx_nxt;
    logic [c_TMO_W-1:0]   r_tmo_cnt,   w_tmo_cnt_nxt;
    logic                 r_err_to,    w_err_to_nxt;
    logic                 r_err_cmd,   w_err_cmd_nxt;
    logic [3:0]           r_frame_cnt, w_frame_cnt_nxt;
    logic [31:0]          r_fword,     w_fword_nxt;
    logic                 r_upd,       w_upd_nxt;
    logic                 r_out_en,    w_out_en_nxt;
    logic [7:0]           r_tx,        w_tx_nxt;
    logic                 r_cs_d;

    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_byte_idx_nxt  = r_byte_idx;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_err_to_nxt    = r_err_to;
        w_err_cmd_nxt   = r_err_cmd;
        w_frame_cnt_nxt = r_frame_cnt;
        w_fword_nxt     = r_fword;
        w_upd_nxt       = 1'b0;
        w_out_en_nxt    = r_out_en;
        // Status reflects the flags as they stand this cycle.
        w_tx_nxt        = {(r_state == S_PEND), r_out_en, r_err_to, r_err_cmd, r_frame_cnt};

        case (r_state)
            S_IDLE: begin
                // cs rising in IDLE means the host has clocked the status
                // out; clear first so a same-cycle new error still sticks.
                if (bus.cs && !r_cs_d) begin
                    w_err_to_nxt  = 1'b0;
                    w_err_cmd_nxt = 1'b0;
                end
                if (bus.rx_valid) begin
                    case (bus.rx_byte)
                        c_CMD_LOAD: begin
                            w_state_nxt    = S_COLLECT;
                            w_byte_idx_nxt = 2'd0;
                            w_tmo_cnt_nxt  = '0;
                        end
                        c_CMD_EN: begin
                            w_out_en_nxt    = 1'b1;
                            w_frame_cnt_nxt = r_frame_cnt + 4'd1;
                        end
                        c_CMD_DIS: begin
                            w_out_en_nxt    = 1'b0;
                            w_frame_cnt_nxt = r_frame_cnt + 4'd1;
                        end
                        default: w_err_cmd_nxt = 1'b1;
                    endcase
                end
            end

            S_COLLECT: begin
                if (bus.cs) begin
                    // Host closed the frame early: drop it quietly.
                    w_state_nxt = S_IDLE;
                end else if (bus.rx_valid) begin
                    w_shadow_nxt  = {r_shadow[23:0], bus.rx_byte};
                    w_tmo_cnt_nxt = '0;
                    if (r_byte_idx == 2'd3) begin
                        w_state_nxt    = S_PEND;
                        w_byte_idx_nxt = 2'd0;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_err_to_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end

            S_PEND: begin
                if (bus.rx_valid) begin
                    w_err_cmd_nxt = 1'b1;
                end
                if (!APPLY_SYNC || bus.dds_strobe) begin
                    w_fword_nxt     = r_shadow;
                    w_upd_nxt       = 1'b1;
                    w_frame_cnt_nxt = r_frame_cnt + 4'd1;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= 32'd0;
            r_byte_idx  <= 2'd0;
            r_tmo_cnt   <= '0;
            r_err_to    <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_frame_cnt <= 4'd0;
            r_fword     <= DEFAULT_FWORD;
            r_upd       <= 1'b0;
            r_out_en    <= 1'b0;
            r_tx        <= 8'h00;
            r_cs_d      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_err_to    <= w_err_to_nxt;
            r_err_cmd   <= w_err_cmd_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_fword     <= w_fword_nxt;
            r_upd       <= w_upd_nxt;
            r_out_en    <= w_out_en_nxt;
            r_tx        <= w_tx_nxt;
            r_cs_d      <= bus.cs;
        end
    end

    assign bus.fword_out = r_fword;
    assign bus.fword_upd = r_upd;
    assign bus.out_en    = r_out_en;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tx_byte   = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_dds_fword_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_fword_ctrl
//  Description : Self-checking bench for dds_fword_ctrl: a vector table for
//                reset/load/control, hand sequences for timeout, abort,
//                strobe alignment and mid-frame reset, then randomized
//                traffic compared against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_fword_ctrl;

    localparam logic [31:0] c_DEF = 32'hDEAD_BEEF;
    localparam int          c_TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_fword_ctrl_if bus_if ();

    dds_fword_ctrl #(
        .DEFAULT_FWORD (c_DEF),
        .TIMEOUT       (c_TMO),
        .APPLY_SYNC    (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view (collected bytes in a queue,
    // silence measured in cycles, frames counted as an integer).
    logic [31:0] m_fword;
    logic        m_upd, m_out_en, m_err_to, m_err_cmd;
    logic        m_in_frame, m_pending, m_cs_prev;
    int          m_frames;
    int          m_silence;
    logic [7:0]  m_data [$];
    logic [31:0] m_word;
    logic [7:0]  m_tx;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  b;
        logic        c;
        logic        s;
        logic [31:0] e_fword;
        logic        e_upd;
        logic        e_oe;
        logic        e_busy;
        logic [7:0]  e_tx;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] b,
                              input logic c, input logic s);
        if (r) begin
            m_fword = c_DEF; m_upd = 0; m_out_en = 0; m_err_to = 0; m_err_cmd = 0;
            m_in_frame = 0; m_pending = 0; m_cs_prev = 0; m_frames = 0;
            m_silence = 0; m_data.delete(); m_tx = 8'h00;
            return;
        end
        m_tx  = {m_pending, m_out_en, m_err_to, m_err_cmd, 4'(m_frames % 16)};
        m_upd = 0;
        if (m_pending) begin
            if (v) m_err_cmd = 1;
            if (s) begin
                m_fword   = m_word;
                m_upd     = 1;
                m_frames  = m_frames + 1;
                m_pending = 0;
            end
        end else if (m_in_frame) begin
            if (c) begin
                m_in_frame = 0;
                m_data.delete();
            end else if (v) begin
                m_data.push_back(b);
                m_silence = 0;
                if (m_data.size() == 4) begin
                    m_word = 0;
                    foreach (m_data[i]) m_word = m_word * 256 + 32'(m_data[i]);
                    m_pending  = 1;
                    m_in_frame = 0;
                    m_data.delete();
                end
            end else begin
                m_silence++;
                if (m_silence == c_TMO) begin
                    m_err_to   = 1;
                    m_in_frame = 0;
                    m_data.delete();
                end
            end
        end else begin
            if (c && !m_cs_prev) begin
                m_err_to  = 0;
                m_err_cmd = 0;
            end
            if (v) begin
                if (b == 8'hA1) begin
                    m_in_frame = 1; m_silence = 0; m_data.delete();
                end else if (b == 8'hA2) begin
                    m_out_en = 1; m_frames = m_frames + 1;
                end else if (b == 8'hA3) begin
                    m_out_en = 0; m_frames = m_frames + 1;
                end else begin
                    m_err_cmd = 1;
                end
            end
        end
        m_cs_prev = c;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " fword_out"}, bus_if.fword_out, m_fword);
        check({tag, " fword_upd"}, 32'(bus_if.fword_upd), 32'(m_upd));
        check({tag, " out_en"},    32'(bus_if.out_en), 32'(m_out_en));
        check({tag, " busy"},      32'(bus_if.busy), 32'(m_in_frame | m_pending));
        check({tag, " tx_byte"},   32'(bus_if.tx_byte), 32'(m_tx));
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] b,
                       input logic c, input logic s, input bit cmp, input string tag);
        rst = r;
        bus_if.rx_valid   = v;
        bus_if.rx_byte    = b;
        bus_if.cs         = c;
        bus_if.dds_strobe = s;
        model_step(r, v, b, c, s);
        @(posedge clk);
        #1;
        if (cmp) compare_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 1, tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        cyc(0, 1, b, 0, 0, 1, tag);
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] b, input logic c,
                       input logic s, input logic [31:0] f, input logic u, input logic oe,
                       input logic bz, input logic [7:0] tx);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.c = c; t.s = s;
        t.e_fword = f; t.e_upd = u; t.e_oe = oe; t.e_busy = bz; t.e_tx = tx;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] rb;
        int dens;

        rst = 1'b1;
        bus_if.rx_valid = 0; bus_if.rx_byte = 0; bus_if.cs = 0; bus_if.dds_strobe = 0;

        //   r  v  byte   cs s  fword         upd oe busy tx
        add(1, 0, 8'h00, 0, 0, c_DEF,         0,  0, 0,  8'h00);
        add(1, 0, 8'h00, 0, 0, c_DEF,         0,  0, 0,  8'h00);
        add(0, 1, 8'hA1, 0, 0, c_DEF,         0,  0, 1,  8'h00);
        add(0, 1, 8'hC5, 0, 0, c_DEF,         0,  0, 1,  8'h00);
        add(0, 1, 8'hB0, 0, 0, c_DEF,         0,  0, 1,  8'h00);
        add(0, 1, 8'h5B, 0, 0, c_DEF,         0,  0, 1,  8'h00);
        add(0, 1, 8'h28, 0, 0, c_DEF,         0,  0, 1,  8'h00);
        add(0, 0, 8'h00, 0, 0, c_DEF,         0,  0, 1,  8'h80);
        add(0, 0, 8'h00, 0, 0, c_DEF,         0,  0, 1,  8'h80);
        add(0, 0, 8'h00, 0, 0, c_DEF,         0,  0, 1,  8'h80);
        add(0, 0, 8'h00, 0, 1, 32'hC5B05B28,  1,  0, 0,  8'h80);
        add(0, 0, 8'h00, 0, 0, 32'hC5B05B28,  0,  0, 0,  8'h01);
        add(0, 1, 8'hA2, 0, 0, 32'hC5B05B28,  0,  1, 0,  8'h01);
        add(0, 0, 8'h00, 0, 0, 32'hC5B05B28,  0,  1, 0,  8'h42);
        add(0, 1, 8'h7F, 0, 0, 32'hC5B05B28,  0,  1, 0,  8'h42);
        add(0, 0, 8'h00, 0, 0, 32'hC5B05B28,  0,  1, 0,  8'h52);
        add(0, 1, 8'hA3, 0, 0, 32'hC5B05B28,  0,  0, 0,  8'h52);
        add(0, 0, 8'h00, 0, 0, 32'hC5B05B28,  0,  0, 0,  8'h13);
        add(0, 0, 8'h00, 1, 0, 32'hC5B05B28,  0,  0, 0,  8'h13);
        add(0, 0, 8'h00, 1, 0, 32'hC5B05B28,  0,  0, 0,  8'h03);
        add(0, 0, 8'h00, 0, 0, 32'hC5B05B28,  0,  0, 0,  8'h03);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].s, 0, "");
            check($sformatf("tbl[%0d] fword_out", i), bus_if.fword_out, tbl[i].e_fword);
            check($sformatf("tbl[%0d] fword_upd", i), 32'(bus_if.fword_upd), 32'(tbl[i].e_upd));
            check($sformatf("tbl[%0d] out_en", i),    32'(bus_if.out_en), 32'(tbl[i].e_oe));
            check($sformatf("tbl[%0d] busy", i),      32'(bus_if.busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl[%0d] tx_byte", i),   32'(bus_if.tx_byte), 32'(tbl[i].e_tx));
        end

        // Timeout: frame dies after exactly c_TMO silent cycles.
        send(8'hA1, "tmo"); send(8'h12, "tmo"); send(8'h34, "tmo");
        idle(c_TMO - 1, "tmo");
        check("tmo busy before limit", 32'(bus_if.busy), 32'd1);
        idle(1, "tmo");
        check("tmo busy at limit", 32'(bus_if.busy), 32'd0);
        idle(1, "tmo");
        check("tmo err_to flag", 32'(bus_if.tx_byte[5]), 32'd1);
        check("tmo fword kept", bus_if.fword_out, 32'hC5B05B28);

        // Clear errors with a cs pulse, then abort a frame via cs.
        cyc(0, 0, 8'h00, 1, 0, 1, "clr"); cyc(0, 0, 8'h00, 0, 0, 1, "clr");
        send(8'hA1, "abort"); send(8'h12, "abort");
        cyc(0, 0, 8'h00, 1, 0, 1, "abort");
        check("abort busy", 32'(bus_if.busy), 32'd0);
        cyc(0, 0, 8'h00, 0, 0, 1, "abort");
        idle(1, "abort");
        check("abort no error", 32'(bus_if.tx_byte[5:4]), 32'd0);

        // Full frame; strobe coincident with 4th byte must be ignored.
        send(8'hA1, "load2"); send(8'h11, "load2"); send(8'h22, "load2"); send(8'h33, "load2");
        cyc(0, 1, 8'h44, 0, 1, 1, "load2");
        check("strobe with last byte ignored", bus_if.fword_out, 32'hC5B05B28);
        idle(3, "load2");
        cyc(0, 0, 8'h00, 0, 1, 1, "load2");
        check("load2 fword", bus_if.fword_out, 32'h11223344);
        check("load2 upd", 32'(bus_if.fword_upd), 32'd1);
        idle(1, "load2");
        check("load2 upd single", 32'(bus_if.fword_upd), 32'd0);

        // Reset in the middle of a frame, then a clean load.
        send(8'hA2, "mid"); send(8'hA1, "mid"); send(8'hAA, "mid"); send(8'hBB, "mid");
        cyc(1, 0, 8'h00, 0, 0, 1, "rst"); cyc(1, 0, 8'h00, 0, 0, 1, "rst");
        check("rst fword", bus_if.fword_out, c_DEF);
        check("rst out_en", 32'(bus_if.out_en), 32'd0);
        check("rst busy", 32'(bus_if.busy), 32'd0);
        check("rst tx", 32'(bus_if.tx_byte), 32'd0);
        send(8'hA1, "load3"); send(8'h01, "load3"); send(8'h02, "load3");
        send(8'h03, "load3"); send(8'h04, "load3");
        send(8'h55, "pendbyte");  // byte while pending: dropped, flagged
        cyc(0, 0, 8'h00, 0, 1, 1, "load3");
        check("load3 fword", bus_if.fword_out, 32'h01020304);
        idle(1, "load3");
        check("pend byte err_cmd", 32'(bus_if.tx_byte[4]), 32'd1);

        // frame_cnt wrap: 1 + 15 = 16 -> 0
        for (int i = 0; i < 15; i++) send(8'hA2, "wrap");
        idle(1, "wrap");
        check("frame_cnt wrap", 32'(bus_if.tx_byte[3:0]), 32'd0);

        // Randomized traffic against the model.
        dens = 30;
        for (int n = 0; n < 4000; n++) begin
            int k;
            logic v, c, s, r;
            if (n % 60 == 0) dens = ($urandom_range(0, 1) != 0) ? 40 : 4;
            k  = $urandom_range(0, 9);
            rb = (k < 4) ? 8'hA1 : (k == 4) ? 8'hA2 : (k == 5) ? 8'hA3 : 8'($urandom);
            v  = ($urandom_range(0, 99) < dens);
            c  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 15);
            r  = ($urandom_range(0, 599) == 0);
            cyc(r, v, rb, c, s, 1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
